icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache; successor to the fixed 128-word
//  instruction ROM. Returns the fetch word in the same cycle on a hit and stalls
//  the core on a miss. On a miss it refills a whole line, one word at a time,
//  from a backing instruction memory. Supports a single-cycle flush.
//  Sits between each core's PC/fetch stage and the shared instruction memory.
// PARAMETERS
//  ADDR_W          32  byte-address width of A and mem_addr
//  DATA_W          32  instruction word width
//  LINES           16  number of cache lines (power of 2, >=2)
//  WORDS_PER_LINE   4  words per line (power of 2, >=2)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous reset, active-low
//  A          in   ADDR_W  fetch byte address; A[1:0] ignored
//  req        in   1       fetch request valid
//  flush      in   1       invalidate all lines
//  RD         out  DATA_W  fetched instruction (valid when req & hit)
//  hit        out  1       req & tag match & line valid (combinational)
//  stall      out  1       req & ~hit, or FSM not IDLE
//  mem_req    out  1       word read request to backing memory
//  mem_addr   out  ADDR_W  word-aligned byte address of requested word
//  mem_rdata  in   DATA_W  backing-memory read data
//  mem_valid  in   1       mem_rdata valid; completes the outstanding mem_req
//  hit_cnt    out  32      saturating count of hit fetches
//  miss_cnt   out  32      saturating count of misses (counted once per refill)
// BEHAVIOUR
//  - Address split: off = A[2 +: OFF_W], idx = A[2+OFF_W +: IDX_W], tag = rest;
//    OFF_W = log2(WORDS_PER_LINE), IDX_W = log2(LINES).
//  - Reset (async, rst_n=0): all valid bits 0, state IDLE, refill counter 0,
//    hit_cnt=miss_cnt=0, mem_req=0, mem_addr=0. RD/hit/stall follow combinational
//    rules (hit=0 after reset). Tag and data arrays are not reset.
//  - Hit: in IDLE with req=1 and a matching valid line, RD = data[idx][off] in
//    the same cycle; hit=1; stall=0; hit_cnt += 1.
//  - Miss: IDLE, req=1, no hit -> stall=1. Next edge: latch tag/idx and the
//    line base address, miss_cnt += 1, state -> REFILL.
//  - REFILL: mem_req=1, mem_addr = base + 4*cnt. At most one word outstanding.
//    When mem_valid=1: data[idx][cnt] <= mem_rdata, cnt += 1. When the last
//    word arrives: tag[idx] <= tag, valid[idx] <= 1, cnt <= 0, state -> IDLE.
//    mem_req is held until mem_valid; no timeout.
//  - First IDLE cycle after a refill: the same A hits (1-cycle replay).
//  - RD=0 when hit=0. A changing during REFILL is ignored until IDLE.
//  - flush=1 (any state): next edge clears all valid bits. In REFILL it also
//    aborts the refill: state -> IDLE, cnt=0, line left invalid, and any
//    mem_valid in that cycle is discarded. flush with req in IDLE: hit is still
//    evaluated that cycle, but the flush is applied first, so the next fetch misses.
//  - mem_valid while IDLE (spurious): ignored.
//  - Counters saturate at 32'hFFFF_FFFF; no wrap.
//  - rst_n asserted mid-refill: immediate IDLE, all lines invalid, mem_req=0.
// STRUCTURE
//  - icache_pkg: typedef enum logic {IDLE, REFILL} icache_state_t; functions
//    for OFF_W/IDX_W/TAG_W derived from the parameters.
//  - Sub-module icache_data_ram: LINES*WORDS_PER_LINE x DATA_W array with an
//    asynchronous read port and a synchronous write port (no reset).
//  - Top-level: tag/valid arrays, FSM, refill counter, perf counters.
// TESTING (defaults, zero-latency memory model unless noted)
//  1. Reset, then req=1, A=0x00 -> stall=1, mem_addr=0x00,0x04,0x08,0x0C
//     in order, then hit=1, RD=mem[0]; miss_cnt=1.
//  2. After 1: A=0x04,0x08,0x0C -> hit on each in 1 cycle, RD=mem[1..3],
//     hit_cnt=4 (including the replay of A=0x00).
//  3. Conflict: A=0x000 then A=0x100 (same idx 0, new tag) -> second fetch
//     refills; then A=0x000 misses again; miss_cnt=3.
//  4. Memory latency of 3 cycles per word -> mem_req held; stall lasts
//     >=4*4 cycles; the line is valid only after the 4th mem_valid.
//  5. flush asserted on the 2nd mem_valid of a refill -> state IDLE, that word
//     is discarded, the next req to the same line refills from word 0.
//  6. rst_n=0 mid-refill and also with a valid line -> mem_req=0 at once; the
//     following fetch to the formerly valid line misses; both counters are 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {IDLE, REFILL} icache_state_t;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - 2 - $clog2(lines) - $clog2(words_per_line);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and backing-memory-side signals of the instruction cache.
interface icache_dm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] A;
  logic              req;
  logic              flush;
  logic [DATA_W-1:0] RD;
  logic              hit;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport master (
    output A, req, flush, mem_rdata, mem_valid,
    input  RD, hit, stall, mem_req, mem_addr
  );

  modport slave (
    input  A, req, flush, mem_rdata, mem_valid,
    output RD, hit, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_data_ram.sv
// Cache data store: asynchronous read, synchronous write, contents not reset.
module icache_data_ram #(
  parameter int AW     = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hit, word-by-word line
// refill on miss, single-cycle flush, saturating hit/miss counters.
module icache_dm
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  icache_dm_if.slave  bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int OFF_W = off_w(WORDS_PER_LINE);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
  localparam int LN_W  = TAG_W + IDX_W;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_a;

  assign off      = bus.A[2 +: OFF_W];
  assign idx      = bus.A[2+OFF_W +: IDX_W];
  assign tag      = bus.A[ADDR_W-1 -: TAG_W];
  assign unused_a = ^bus.A[1:0];

  icache_state_t    state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [LN_W-1:0]  line_q, line_d;    // {tag, idx} of the line being refilled
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];
  logic [31:0]      hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  ref_idx;
  logic [TAG_W-1:0]  ref_tag;
  logic              hit, last, wr_en;
  logic [DATA_W-1:0] rdata;

  assign ref_idx = line_q[IDX_W-1:0];
  assign ref_tag = line_q[IDX_W +: TAG_W];
  assign last    = (cnt_q == OFF_W'(WORDS_PER_LINE-1));
  assign hit     = bus.req && (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
  // A flush in the same cycle as a refill beat discards that beat.
  assign wr_en   = (state_q == REFILL) && bus.mem_valid && !bus.flush;

  icache_data_ram #(.AW(IDX_W + OFF_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({ref_idx, cnt_q}),
    .wdata (bus.mem_rdata),
    .raddr ({idx, off}),
    .rdata (rdata)
  );

  assign bus.hit      = hit;
  assign bus.RD       = hit ? rdata : '0;
  assign bus.stall    = (bus.req && !hit) || (state_q != IDLE);
  assign bus.mem_req  = (state_q == REFILL);
  assign bus.mem_addr = (state_q == REFILL) ? {line_q, cnt_q, 2'b00} : '0;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        // A miss coinciding with flush waits a cycle so the flush wins cleanly.
        if (bus.req && !hit && !bus.flush) begin
          line_d     = {tag, idx};
          cnt_d      = '0;
          miss_cnt_d = sat_inc(miss_cnt_q);
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.mem_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            tag_d[ref_idx]   = ref_tag;
            valid_d[ref_idx] = 1'b1;
            cnt_d            = '0;
            state_d          = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (hit) hit_cnt_d = sat_inc(hit_cnt_q);
    if (bus.flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end
endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed table, hand-written corner sequences, random fetches
// checked against a line-presence model and a hashed backing memory.
module tb_icache_dm;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] hit_cnt, miss_cnt;

  icache_dm_if ifc ();

  icache_dm u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc.slave),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // Backing memory: word value is a hash of its address; lat = extra wait cycles per word.
  int          lat = 0;
  logic        spur = 1'b0;
  int          wait_c = 0;
  logic [31:0] last_addr = '0;
  logic        last_req = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign ifc.mem_rdata = mem_word(ifc.mem_addr);
  assign ifc.mem_valid = spur | (ifc.mem_req && (wait_c >= lat));

  always @(negedge clk) begin
    if (!ifc.mem_req || !last_req || (ifc.mem_addr != last_addr)) wait_c = 0;
    else wait_c = wait_c + 1;
    last_addr = ifc.mem_addr;
    last_req  = ifc.mem_req;
  end

  // Reference model: which line number each index currently holds.
  logic        mvalid [16];
  logic [31:0] mline  [16];
  int          exp_hits, exp_misses;
  int          n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    return mvalid[(a >> 4) & 32'hF] && (mline[(a >> 4) & 32'hF] == (a >> 4));
  endfunction

  // Starts at posedge+1, ends at posedge+1 after the hitting cycle.
  task automatic do_fetch(input logic [31:0] a, output int stall_cyc);
    logic h;
    int   k;
    bit   done;
    ifc.A = a; ifc.req = 1'b1;
    #1;
    h = model_hit(a);
    stall_cyc = 0;
    chk("hit", ifc.hit, h);
    chk("stall", ifc.stall, !h);
    if (h) chk("rd", ifc.RD, mem_word(a));
    else   chk("rd_zero_on_miss", ifc.RD, 32'h0);
    if (!h) begin
      exp_misses++;
      k = 0; done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clk); #1;
        if (ifc.hit) done = 1;
        else begin
          stall_cyc++;
          if (ifc.mem_req && ifc.mem_valid) begin
            chk("mem_addr", ifc.mem_addr, (a & ~32'hF) + 32'(4 * k));
            k++;
          end
        end
      end
      if (!done) chk("refill_timeout", 32'h0, 32'h1);
      chk("refill_words", k, 4);
      chk("replay_rd", ifc.RD, mem_word(a));
      mvalid[(a >> 4) & 32'hF] = 1'b1;
      mline[(a >> 4) & 32'hF]  = a >> 4;
    end
    exp_hits++;
    @(posedge clk); #1;
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
  endtask

  typedef struct {
    logic [31:0] a;
    bit          miss;
    int          hc;
    int          mc;
  } vec_t;

  vec_t tbl [11];
  int   sc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h000, 1, 1, 1};
    tbl[1]  = '{32'h004, 0, 2, 1};
    tbl[2]  = '{32'h008, 0, 3, 1};
    tbl[3]  = '{32'h00C, 0, 4, 1};
    tbl[4]  = '{32'h100, 1, 5, 2};
    tbl[5]  = '{32'h000, 1, 6, 3};
    tbl[6]  = '{32'h010, 1, 7, 4};
    tbl[7]  = '{32'h01C, 0, 8, 4};
    tbl[8]  = '{32'h100, 1, 9, 5};
    tbl[9]  = '{32'h3F0, 1, 10, 6};
    tbl[10] = '{32'h3F4, 0, 11, 6};

    model_clear();
    exp_hits = 0; exp_misses = 0;
    ifc.A = '0; ifc.req = 1'b0; ifc.flush = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_hit", ifc.hit, 0);
    chk("rst_stall", ifc.stall, 0);
    chk("rst_mem_req", ifc.mem_req, 0);
    chk("rst_mem_addr", ifc.mem_addr, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table: cold miss, line hits, conflict misses.
    foreach (tbl[i]) begin
      do_fetch(tbl[i].a, sc);
      chk("tbl_miss", (sc > 0), tbl[i].miss);
      chk("tbl_hit_cnt", hit_cnt, tbl[i].hc);
      chk("tbl_miss_cnt", miss_cnt, tbl[i].mc);
    end

    // Slow memory: each word takes 4 cycles, mem_req held throughout.
    lat = 3;
    do_fetch(32'h200, sc);
    chk("lat_stall_ge16", (sc >= 16), 1);
    lat = 0;

    // Flush alongside a hitting fetch: hit reported now, next fetch misses.
    ifc.A = 32'h204; ifc.req = 1'b1; ifc.flush = 1'b1;
    #1;
    chk("flush_hit", ifc.hit, 1);
    chk("flush_hit_rd", ifc.RD, mem_word(32'h204));
    exp_hits++;
    @(posedge clk); #1 ifc.flush = 1'b0;
    model_clear();
    do_fetch(32'h204, sc);
    chk("after_flush_miss", (sc > 0), 1);

    // Flush on the second refill beat aborts the refill.
    ifc.A = 32'h400; ifc.req = 1'b1;
    #1 chk("abort_stall", ifc.stall, 1);
    @(posedge clk); #1;
    exp_misses++;
    chk("abort_w0_addr", ifc.mem_addr, 32'h400);
    @(posedge clk); #1;
    chk("abort_w1_addr", ifc.mem_addr, 32'h404);
    ifc.flush = 1'b1;
    #1 chk("abort_w1_valid", ifc.mem_valid, 1);
    @(posedge clk); #1 ifc.flush = 1'b0;
    model_clear();
    chk("abort_idle_mem_req", ifc.mem_req, 0);
    chk("abort_no_hit", ifc.hit, 0);
    ifc.req = 1'b0; spur = 1'b1;
    @(posedge clk); #1;
    chk("spurious_mem_req", ifc.mem_req, 0);
    chk("abort_miss_cnt", miss_cnt, exp_misses);
    chk("abort_hit_cnt", hit_cnt, exp_hits);
    spur = 1'b0;
    do_fetch(32'h400, sc);

    // Reset in the middle of a slow refill, with line 0x400 valid.
    lat = 3;
    ifc.A = 32'h520; ifc.req = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("midrefill_mem_req", ifc.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", ifc.mem_req, 0);
    chk("rst_mid_hit_cnt", hit_cnt, 0);
    chk("rst_mid_miss_cnt", miss_cnt, 0);
    model_clear();
    exp_hits = 0; exp_misses = 0;
    ifc.req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    lat = 0;
    @(posedge clk); #1;
    do_fetch(32'h400, sc);
    chk("post_rst_miss", (sc > 0), 1);

    // Random fetches with random memory latency and occasional flushes.
    for (int n = 0; n < 120; n++) begin
      lat = $urandom_range(0, 2);
      do_fetch($urandom_range(0, 32'h7FF) & ~32'h3, sc);
      if ($urandom_range(0, 9) == 0) begin
        ifc.req = 1'b0; ifc.flush = 1'b1;
        @(posedge clk); #1 ifc.flush = 1'b0;
        model_clear();
      end
    end
    ifc.req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
